// File: rtl/adder_pkg.sv
// Shared types and default sizing for the adder datapath and its result buffer.
package adder_pkg;

    localparam int unsigned ADDER_W     = 32;
    localparam int unsigned ADDER_DEPTH = 4;

    typedef struct packed {
        logic [ADDER_W-1:0] sum;
        logic               cout;
        logic               of;
    } adder_result_t;

endpackage

// File: rtl/adder_result_buffer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/adder_result_buffer.sv
// Capture FIFO for adder results with valid/ready output and overflow statistics.
// Head entry is held in a register so out_* never see a combinational path from in_*.
module adder_result_buffer
    import adder_pkg::*;
#(
    parameter int unsigned W     = ADDER_W,
    parameter int unsigned DEPTH = ADDER_DEPTH,
    parameter int unsigned CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             in_sum,
    input  logic                     in_cout,
    input  logic                     in_of,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_sum,
    output logic                     out_cout,
    output logic                     out_of,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     of_sticky,
    output logic [CNT_W-1:0]         of_count,
    input  logic                     clr_stats
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    // Storage uses the package result type, so the data width must match it.
    if (W != ADDER_W) begin : g_width_check
        $error("adder_result_buffer: W must equal adder_pkg::ADDER_W");
    end

    adder_result_t mem_q [DEPTH];
    adder_result_t head_q;
    adder_result_t head_d;
    adder_result_t in_ent;

    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] wr_ptr_d;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] rd_ptr_d;
    logic [PW-1:0] level_q;
    logic [PW-1:0] level_d;
    logic          in_ready_q;
    logic          in_ready_d;
    logic          out_valid_q;
    logic          out_valid_d;
    logic          sticky_q;
    logic          sticky_d;
    logic          push;
    logic          pop;

    assign push = in_valid & in_ready_q;
    assign pop  = out_valid_q & out_ready;

    always_comb begin
        in_ent      = '0;
        in_ent.sum  = in_sum;
        in_ent.cout = in_cout;
        in_ent.of   = in_of;
    end

    // Next pointers, occupancy and the entry that will sit at the head.
    always_comb begin
        wr_ptr_d    = wr_ptr_q + PW'(push);
        rd_ptr_d    = rd_ptr_q + PW'(pop);
        level_d     = wr_ptr_d - rd_ptr_d;
        in_ready_d  = (level_d != PW'(DEPTH));
        out_valid_d = (level_d != '0);
        head_d      = head_q;
        if (push && (rd_ptr_d == wr_ptr_q)) begin
            head_d = in_ent;
        end else if (out_valid_d) begin
            head_d = mem_q[rd_ptr_d[AW-1:0]];
        end
    end

    always_comb begin
        sticky_d = sticky_q;
        if (clr_stats) begin
            sticky_d = 1'b0;
        end else if (push && in_of) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_ent;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            head_q      <= '0;
            sticky_q    <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            head_q      <= head_d;
            sticky_q    <= sticky_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_of_count (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (push & in_of),
        .clr_i (clr_stats),
        .cnt_o (of_count)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = head_q.sum;
    assign out_cout  = head_q.cout;
    assign out_of    = head_q.of;
    assign level     = level_q;
    assign of_sticky = sticky_q;

endmodule

// File: tb/tb_adder_result_buffer.sv
// Directed-vector bench for adder_result_buffer with hand-computed expectations.
module tb_adder_result_buffer;

    localparam int unsigned W     = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 8;

    logic                   clk;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [W-1:0]           in_sum;
    logic                   in_cout;
    logic                   in_of;
    logic                   out_valid;
    logic                   out_ready;
    logic [W-1:0]           out_sum;
    logic                   out_cout;
    logic                   out_of;
    logic [$clog2(DEPTH):0] level;
    logic                   of_sticky;
    logic [CNT_W-1:0]       of_count;
    logic                   clr_stats;

    int n_vec;
    int n_err;

    adder_result_buffer #(
        .W     (W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_cout   (in_cout),
        .in_of     (in_of),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_of    (out_of),
        .level     (level),
        .of_sticky (of_sticky),
        .of_count  (of_count),
        .clr_stats (clr_stats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just past the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] s, input logic c, input logic o,
                         input logic rdy);
        in_valid  = v;
        in_sum    = s;
        in_cout   = c;
        in_of     = o;
        out_ready = rdy;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        clr_stats = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        repeat (2) step();
        rst_n = 1'b1;
        step();

        check_val("rst_level", 64'(level), 64'd0);
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_in_ready", 64'(in_ready), 64'd1);
        check_val("rst_sticky", 64'(of_sticky), 64'd0);
        check_val("rst_count", 64'(of_count), 64'd0);
        check_val("rst_out_sum", 64'(out_sum), 64'd0);

        // Fill to full, then an ignored fifth push.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, W'(i), 1'b0, 1'b0, 1'b0);
            step();
        end
        check_val("fill_level", 64'(level), 64'd4);
        check_val("fill_in_ready", 64'(in_ready), 64'd0);
        check_val("fill_out_sum", 64'(out_sum), 64'h1);
        drive(1'b1, W'(5), 1'b0, 1'b0, 1'b0);
        step();
        check_val("full_push_level", 64'(level), 64'd4);
        check_val("full_push_head", 64'(out_sum), 64'h1);

        // Drain in order.
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            check_val("drain_sum", 64'(out_sum), 64'(i));
            check_val("drain_valid", 64'(out_valid), 64'd1);
            step();
        end
        check_val("drain_out_valid", 64'(out_valid), 64'd0);
        check_val("drain_level", 64'(level), 64'd0);

        // Simultaneous push/pop at level 2.
        drive(1'b1, W'(32'h10), 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, W'(32'h20), 1'b0, 1'b0, 1'b0);
        step();
        check_val("pp_level_pre", 64'(level), 64'd2);
        drive(1'b1, W'(32'hAA), 1'b0, 1'b0, 1'b1);
        step();
        check_val("pp_level", 64'(level), 64'd2);
        check_val("pp_head_20", 64'(out_sum), 64'h20);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step();
        check_val("pp_head_aa", 64'(out_sum), 64'hAA);
        step();
        check_val("pp_empty", 64'(out_valid), 64'd0);

        // Streaming: one in, one out every cycle, occupancy held at one.
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, W'(32'h100 + k), 1'b0, 1'b0, 1'b1);
            step();
            check_val("stream_sum", 64'(out_sum), 64'(32'h100 + k));
            check_val("stream_level", 64'(level), 64'd1);
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step();
        check_val("stream_empty", 64'(level), 64'd0);
        check_val("stream_no_of", 64'(of_count), 64'd0);

        // Overflow statistics with pattern 1,0,1.
        drive(1'b1, W'(32'h8000_0000), 1'b1, 1'b1, 1'b1);
        step();
        check_val("of_head_of", 64'(out_of), 64'd1);
        check_val("of_head_cout", 64'(out_cout), 64'd1);
        drive(1'b1, W'(32'h8000_0000), 1'b1, 1'b0, 1'b1);
        step();
        check_val("of_head_of0", 64'(out_of), 64'd0);
        drive(1'b1, W'(32'h8000_0000), 1'b1, 1'b1, 1'b1);
        step();
        check_val("of_sticky", 64'(of_sticky), 64'd1);
        check_val("of_count2", 64'(of_count), 64'd2);
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        check_val("clr_sticky", 64'(of_sticky), 64'd0);
        check_val("clr_count", 64'(of_count), 64'd0);

        // Saturation: 300 overflow pushes while popping continuously.
        drive(1'b1, W'(32'h8000_0000), 1'b0, 1'b1, 1'b1);
        for (int k = 1; k <= 300; k++) begin
            step();
            if (k == 254) check_val("sat_254", 64'(of_count), 64'd254);
            if (k == 255) check_val("sat_255", 64'(of_count), 64'd255);
        end
        check_val("sat_hold", 64'(of_count), 64'd255);
        check_val("sat_sticky", 64'(of_sticky), 64'd1);
        check_val("sat_level", 64'(level), 64'd1);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step();
        check_val("sat_pop_count", 64'(of_count), 64'd255);

        // Async reset at level 3, between edges.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, W'(32'hC0 + i), 1'b0, 1'b0, 1'b0);
            step();
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check_val("ar_level_pre", 64'(level), 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("ar_out_valid", 64'(out_valid), 64'd0);
        check_val("ar_level", 64'(level), 64'd0);
        check_val("ar_count", 64'(of_count), 64'd0);
        check_val("ar_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, W'(32'h5A5A_5A5A), 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check_val("ar_post_valid", 64'(out_valid), 64'd1);
        check_val("ar_post_sum", 64'(out_sum), 64'h5A5A_5A5A);
        check_val("ar_post_level", 64'(level), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
